// File: rtl/serial_out_pkg.sv
// serial_out_pkg: shared types and defaults for the bit-serial LED presenter
package serial_out_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam logic LED_OFF = 1'b1;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low key, pulsing press on each debounced fall
module key_debounce
  import serial_out_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic k1,
  input  logic k_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1, k_s, level, flip;
  logic [CW-1:0] cnt;
  // level accepts k_s only after DEBOUNCE_CYCLES consecutive disagreeing samples
  assign flip = (k_s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge k1) begin
    if (!k1) begin
      s1 <= 1'b1;
      k_s <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= k_raw;
      k_s <= s1;
      cnt <= (k_s == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? k_s : level;
      press <= flip & ~k_s;
    end
  end
endmodule

// File: rtl/serial_out.sv
// serial_out: latches a word and steps it LSB first onto an active-low LED, one bit per key press
module serial_out
  import serial_out_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                     clk,
  input  logic                     k1,
  input  logic                     k0,
  input  logic                     load,
  input  logic [WIDTH-1:0]         data,
  output logic                     led_bit,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic press, last, accept, step;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk  (clk),
    .k1   (k1),
    .k_raw(k0),
    .press(press)
  );
  // load only counts outside SHOW, and then it pre-empts a coincident press
  assign accept = load && state != SHOW;
  assign last = bit_idx == LAST;
  assign step = state == SHOW && press;
  always_ff @(posedge clk or negedge k1) begin
    if (!k1) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = accept ? SHOW : (step && last) ? DONE : state;
  end
  always_ff @(posedge clk or negedge k1) begin
    if (!k1) begin
      shreg <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      shreg <= data;
      bit_idx <= '0;
    end else if (step && !last) begin
      shreg <= shreg >> 1;
      bit_idx <= bit_idx + 1'b1;
    end
  end
  always_comb begin
    busy = state == SHOW;
    done = state == DONE;
    led_bit = busy ? ~shreg[0] : LED_OFF;
  end
endmodule

// File: tb/tb_serial_out.sv
// tb_serial_out: directed scenario checks for serial_out with a short debounce window
module tb_serial_out;
  localparam int W = 8;
  localparam int DC = 4;
  logic clk = 1'b0, k1 = 1'b0, k0 = 1'b1, load = 1'b0;
  logic [W-1:0] data = '0;
  logic led_bit, busy, done;
  logic [2:0] bit_idx;
  int errors = 0, checks = 0;

  serial_out #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .k1(k1), .k0(k0), .load(load), .data(data),
    .led_bit(led_bit), .bit_idx(bit_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_press(input int lo, input int hi);
    k0 = 1'b0;
    cyc(lo);
    k0 = 1'b1;
    cyc(hi);
  endtask

  task automatic do_load(input logic [W-1:0] d);
    load = 1'b1;
    data = d;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    k1 = 1'b0;
    cyc(3);
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL reset_led: got %b want 1", led_bit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bit_idx); end
    k1 = 1'b1;
    cyc(2);
    key_press(10, 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_press_busy: got %b want 0", busy); end
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL idle_press_idx: got %0d want 0", bit_idx); end
  endtask

  task automatic test_async_reset;
    do_load(8'hFF);
    key_press(10, 10);
    checks++; if (bit_idx !== 3'd1) begin errors++; $display("FAIL ar_pre_idx: got %0d want 1", bit_idx); end
    checks++; if (led_bit !== 1'b0) begin errors++; $display("FAIL ar_pre_led: got %b want 0", led_bit); end
    @(posedge clk);
    #2 k1 = 1'b0;
    #1;
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL ar_led: got %b want 1", led_bit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ar_done: got %b want 0", done); end
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL ar_idx: got %0d want 0", bit_idx); end
    @(negedge clk);
    k1 = 1'b1;
    cyc(1);
    key_press(10, 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_post_busy: got %b want 0", busy); end
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL ar_post_idx: got %0d want 0", bit_idx); end
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL ar_post_led: got %b want 1", led_bit); end
  endtask

  task automatic test_full_word;
    logic [7:0] exp_led;
    exp_led = 8'b0101_1010;
    do_load(8'hA5);
    for (int i = 0; i < 8; i++) begin
      checks++; if (bit_idx !== 3'(i)) begin errors++; $display("FAIL word_idx%0d: got %0d want %0d", i, bit_idx, i); end
      checks++; if (led_bit !== exp_led[i]) begin errors++; $display("FAIL word_led%0d: got %b want %b", i, led_bit, exp_led[i]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL word_busy%0d: got %b want 1", i, busy); end
      key_press(10, 10);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL word_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL word_end_busy: got %b want 0", busy); end
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL word_end_led: got %b want 1", led_bit); end
    checks++; if (bit_idx !== 3'd7) begin errors++; $display("FAIL word_end_idx: got %0d want 7", bit_idx); end
  endtask

  task automatic test_bounce;
    do_load(8'hA5);
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL bnc_start_idx: got %0d want 0", bit_idx); end
    k0 = 1'b0;
    cyc(3);
    k0 = 1'b1;
    cyc(1);
    k0 = 1'b0;
    cyc(6);
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL bnc_edge6_idx: got %0d want 0", bit_idx); end
    cyc(1);
    checks++; if (bit_idx !== 3'd1) begin errors++; $display("FAIL bnc_edge7_idx: got %0d want 1", bit_idx); end
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL bnc_led: got %b want 1", led_bit); end
    cyc(5);
    k0 = 1'b1;
    cyc(10);
    checks++; if (bit_idx !== 3'd1) begin errors++; $display("FAIL bnc_final_idx: got %0d want 1", bit_idx); end
  endtask

  task automatic test_held;
    k0 = 1'b0;
    cyc(60);
    checks++; if (bit_idx !== 3'd2) begin errors++; $display("FAIL held_idx: got %0d want 2", bit_idx); end
    k0 = 1'b1;
    cyc(8);
    k0 = 1'b0;
    cyc(10);
    checks++; if (bit_idx !== 3'd3) begin errors++; $display("FAIL held_second_idx: got %0d want 3", bit_idx); end
    k0 = 1'b1;
    cyc(10);
  endtask

  task automatic test_load_rules;
    logic [7:0] word;
    word = 8'hA5;
    do_load(8'h3C);
    checks++; if (bit_idx !== 3'd3) begin errors++; $display("FAIL show_load_idx: got %0d want 3", bit_idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL show_load_busy: got %b want 1", busy); end
    checks++; if (led_bit !== ~word[3]) begin errors++; $display("FAIL show_load_led3: got %b want %b", led_bit, ~word[3]); end
    for (int i = 4; i < 8; i++) begin
      key_press(10, 10);
      checks++; if (bit_idx !== 3'(i)) begin errors++; $display("FAIL show_load_idx%0d: got %0d want %0d", i, bit_idx, i); end
      checks++; if (led_bit !== ~word[i]) begin errors++; $display("FAIL show_load_led%0d: got %b want %b", i, led_bit, ~word[i]); end
    end
    key_press(10, 10);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rules_done: got %b want 1", done); end
    k0 = 1'b0;
    cyc(6);
    load = 1'b1;
    data = 8'h01;
    cyc(1);
    load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coin_busy: got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL coin_done: got %b want 0", done); end
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL coin_idx: got %0d want 0", bit_idx); end
    checks++; if (led_bit !== 1'b0) begin errors++; $display("FAIL coin_led: got %b want 0", led_bit); end
    cyc(20);
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL coin_held_idx: got %0d want 0", bit_idx); end
    k0 = 1'b1;
    cyc(10);
  endtask

  task automatic test_latency;
    k1 = 1'b0;
    cyc(1);
    k1 = 1'b1;
    cyc(2);
    load = 1'b1;
    data = 8'h02;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_pre_busy: got %b want 0", busy); end
    cyc(1);
    load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy); end
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL lat_led: got %b want 1", led_bit); end
    k0 = 1'b0;
    cyc(DC + 2);
    checks++; if (led_bit !== 1'b1) begin errors++; $display("FAIL lat_edge6_led: got %b want 1", led_bit); end
    cyc(1);
    checks++; if (led_bit !== 1'b0) begin errors++; $display("FAIL lat_edge7_led: got %b want 0", led_bit); end
    checks++; if (bit_idx !== 3'd1) begin errors++; $display("FAIL lat_edge7_idx: got %0d want 1", bit_idx); end
    k0 = 1'b1;
    cyc(10);
  endtask

  initial begin
    cyc(1);
    test_reset;
    test_async_reset;
    test_full_word;
    test_bounce;
    test_held;
    test_load_rules;
    test_latency;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
